// File: rtl/mult_sequencer.sv
// Multi-cycle shift-add multiplier controller for EX; one Adder reused per bit.
// Optional MULT_SIGNED_EN adds signed_i and sign-magnitude handling.

module Adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
`ifdef MULT_SIGNED_EN
  input  logic             signed_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_hi_o,
  output logic [WIDTH-1:0] prod_lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

  logic [WIDTH-1:0] add_in;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [2*WIDTH-1:0] prod_fin;

  logic [WIDTH-1:0] a_ld;
  logic [WIDTH-1:0] b_ld;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic neg_ld;
`endif

  assign add_in = lo_q[0] ? mcand_q : '0;

  Adder #(.W(WIDTH)) u_add (
    .a_i   (hi_q),
    .b_i   (add_in),
    .sum_o (sum)
  );

  // Adder has no carry-out; recover it from unsigned wrap-around.
  assign carry = (sum < hi_q);
  assign hi_nx = {carry, sum[WIDTH-1:1]};
  assign lo_nx = {sum[0], lo_q[WIDTH-1:1]};

  always_comb begin
    prod_fin = {hi_nx, lo_nx};
`ifdef MULT_SIGNED_EN
    if (neg_q) begin
      prod_fin = -{hi_nx, lo_nx};
    end
`endif
  end

  // Operands loaded on accept; signed mode feeds magnitudes.
  always_comb begin
    a_ld = src1_i;
    b_ld = src2_i;
`ifdef MULT_SIGNED_EN
    neg_ld = 1'b0;
    if (signed_i) begin
      if (src1_i[WIDTH-1]) a_ld = -src1_i;
      if (src2_i[WIDTH-1]) b_ld = -src2_i;
      neg_ld = src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d = a_ld;
          lo_d    = b_ld;
          hi_d    = '0;
          cnt_d   = '0;
`ifdef MULT_SIGNED_EN
          neg_d   = neg_ld;
`endif
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        hi_d  = hi_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          prod_hi_d = prod_fin[2*WIDTH-1:WIDTH];
          prod_lo_d = prod_fin[WIDTH-1:0];
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (start_i) begin
          mcand_d = a_ld;
          lo_d    = b_ld;
          hi_d    = '0;
          cnt_d   = '0;
`ifdef MULT_SIGNED_EN
          neg_d   = neg_ld;
`endif
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
`ifdef MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
`ifdef MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy_o    = (state_q == S_CALC);
  assign done_o    = (state_q == S_DONE);
  assign prod_hi_o = prod_hi_q;
  assign prod_lo_o = prod_lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: directed vectors, decoupled monitor.
// Signed vectors are compiled in when MULT_SIGNED_EN is defined.

module tb_mult_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        signed_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] prod_hi_o;
  logic [31:0] prod_lo_o;

  int tests = 0;
  int fails = 0;
  int busy_run = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_hold = 64'd0;

  always #5 clk_i = ~clk_i;

  mult_sequencer dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
`ifdef MULT_SIGNED_EN
    .signed_i  (signed_i),
`endif
    .busy_o    (busy_o),
    .done_o    (done_o),
    .prod_hi_o (prod_hi_o),
    .prod_lo_o (prod_lo_o)
  );

  // Monitor: pops expected product on every done pulse.
  always @(negedge clk_i) begin
    logic [63:0] e;
    if (busy_o && done_o) begin
      tests++; fails++;
      $display("FAIL busy_done_overlap: busy=1 done=1, required not both");
    end
    if (done_o) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got %h_%h, required no done",
                 prod_hi_o, prod_lo_o);
      end else begin
        e = exp_q.pop_front();
        if ({prod_hi_o, prod_lo_o} !== e) begin
          fails++;
          $display("FAIL product: got %h_%h, required %h_%h",
                   prod_hi_o, prod_lo_o, e[63:32], e[31:0]);
        end
        exp_hold = e;
      end
      tests++;
      if (busy_run != 32) begin
        fails++;
        $display("FAIL busy_len: got %0d, required 32", busy_run);
      end
      busy_run = 0;
    end else if (busy_o) begin
      busy_run++;
      tests++;
      if ({prod_hi_o, prod_lo_o} !== exp_hold) begin
        fails++;
        $display("FAIL hold_in_calc: got %h_%h, required %h_%h",
                 prod_hi_o, prod_lo_o, exp_hold[63:32], exp_hold[31:0]);
      end
    end else begin
      busy_run = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Waits up to 40 cycles for done; returns cycles waited.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      n++;
      if (done_o) return;
    end
    tests++; fails++;
    $display("FAIL done_timeout: got no done in 40 cycles, required done");
  endtask

  task automatic mul(input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic [63:0] e);
    int n;
    src1_i   = a;
    src2_i   = b;
    signed_i = s;
    start_i  = 1'b1;
    exp_q.push_back(e);
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(n);
    check("latency", 64'(n + 1), 64'd33);
    @(negedge clk_i);
  endtask

  initial begin
    int n;
    int dcount;
    rst_i    = 1'b1;
    start_i  = 1'b0;
    src1_i   = '0;
    src2_i   = '0;
    signed_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_prod", {prod_hi_o, prod_lo_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    mul(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    mul(32'd0, 32'd0, 1'b0, 64'd0);
    mul(32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE);

    // Back-to-back with start held high; junk operands during CALC.
    src1_i  = 32'h0001_0000;
    src2_i  = 32'h0001_0000;
    start_i = 1'b1;
    exp_q.push_back(64'h0000_0001_0000_0000);
    @(negedge clk_i);
    src1_i = 32'hDEAD_BEEF;
    src2_i = 32'h1234_5678;
    wait_done(n);
    src1_i = 32'hFFFF_FFFF;
    src2_i = 32'd2;
    exp_q.push_back(64'h0000_0001_FFFF_FFFE);
    @(negedge clk_i);
    src1_i = 32'hCAFE_F00D;
    src2_i = 32'h0BAD_0BAD;
    wait_done(n);
    check("b2b_period1", 64'(n + 1), 64'd33);
    src1_i = 32'd1000;
    src2_i = 32'd1000;
    exp_q.push_back(64'h0000_0000_000F_4240);
    @(negedge clk_i);
    start_i = 1'b0;
    src1_i  = 32'h5555_5555;
    wait_done(n);
    check("b2b_period2", 64'(n + 1), 64'd33);
    @(negedge clk_i);

    // Reset during iteration 10 of 3x5; start in reset cycle ignored.
    src1_i  = 32'd3;
    src2_i  = 32'd5;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    rst_i   = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = 1'b0;
    exp_hold = 64'd0;
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_done", 64'(done_o), 64'd0);
    check("mid_rst_prod", {prod_hi_o, prod_lo_o}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) dcount++;
    end
    check("no_done_after_rst", 64'(dcount), 64'd0);
    mul(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);

`ifdef MULT_SIGNED_EN
    mul(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    mul(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    mul(32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE);
`endif

    repeat (3) @(negedge clk_i);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle 32×32 shift-add multiplier controller for the EX stage. It sequences a single instance of the team's `Adder` block over WIDTH iterations to produce a 2·WIDTH-bit product. It exposes a start/busy/done handshake so the hazard unit can stall the pipeline while a MULT is in flight. The product is held in HI/LO-style output registers until the next accepted start.

## Interface
- WIDTH, 32, operand width; the product is 2·WIDTH bits.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request a multiply; sampled only when the block can accept.
- src1_i  input  WIDTH  multiplicand; captured on accept.
- src2_i  input  WIDTH  multiplier; captured on accept.
- busy_o  output  1  high while in CALC; the pipeline stalls on it.
- done_o  output  1  one-cycle pulse when a product is valid.
- prod_hi_o  output  WIDTH  upper half of the product.
- prod_lo_o  output  WIDTH  lower half of the product.
- signed_i  input  1  operands are two's complement; present only with MULT_SIGNED_EN.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: start_i=1 accepts the operands.
  - mcand <= src1_i; lo <= src2_i; hi <= 0; cnt <= 0; go to CALC.
- CALC, one iteration per cycle:
  - add = lo[0] ? mcand : 0; sum = Adder(hi, add).
  - carry = (sum < hi), unsigned compare, because the Adder has no carry-out.
  - {hi, lo} <= {carry, sum, lo} >> 1; cnt <= cnt + 1.
  - Leave CALC when cnt == WIDTH-1.
- DONE:
  - done_o=1 for exactly one cycle; prod_hi_o/prod_lo_o are updated from hi/lo on entry.
  - Next state: CALC if start_i=1 (new operands accepted this cycle), else IDLE.
- Product outputs hold their last value in IDLE and CALC. They change only on DONE entry and on reset.
- start_i while busy_o=1 is ignored. There is no queueing, and the in-flight operation is not disturbed.
- Operands of 0 still take the full WIDTH iterations; there is no early termination.
- cnt is a log2(WIDTH)-bit counter. It wraps to 0 on the next accept and is never read outside CALC.

## Timing
- Reset values: busy_o=0, done_o=0, prod_hi_o=0, prod_lo_o=0, state=IDLE, cnt=0.
- Accept at cycle t (IDLE or DONE, start_i=1).
- busy_o is high from t+1 through t+WIDTH.
- done_o and the new product are visible at t+WIDTH+1.
- Latency is WIDTH+1 cycles from accept to done_o. Back-to-back throughput is one product per WIDTH+1 cycles, because start is accepted in DONE.
- Reset asserted in any state, including mid-CALC:
  - Next cycle is IDLE with all outputs at their reset values.
  - The partial product is discarded and no done_o pulse occurs.
  - start_i in the reset cycle is ignored.
- busy_o and done_o are never high in the same cycle.

## Configuration
- MULT_SIGNED_EN defined:
  - The signed_i port exists.
  - With signed_i=1 on accept, the block loads |src1_i| and |src2_i| and registers neg = src1_i[WIDTH-1] ^ src2_i[WIDTH-1].
  - On DONE entry the 2·WIDTH-bit result is two's-complement negated when neg=1.
  - Latency is unchanged.
  - |0x80000000| is treated as unsigned 0x80000000.
- MULT_SIGNED_EN undefined:
  - signed_i is absent and all operands are unsigned.
  - No negation logic is built.

## Test plan
- Reset, then src1_i=7, src2_i=6, start_i pulse:
  - busy_o is high for exactly 32 cycles.
  - done_o pulses once with prod_hi_o=0x00000000 and prod_lo_o=0x0000002A.
- Unsigned src1_i=src2_i=0xFFFFFFFF: product is 0xFFFFFFFE_00000001, which exercises the carry path every iteration.
- Hold start_i high continuously with new operands each DONE cycle:
  - Products complete every 33 cycles.
  - start_i during CALC is ignored and the product outputs stay stable until done_o.
- Assert rst_i for one cycle at iteration 10 of a 3×5 multiply:
  - No done_o follows and all outputs are 0.
  - A subsequent 3×5 yields 0x0000000F.
- MULT_SIGNED_EN, signed_i=1:
  - −3 × 5 → 0xFFFFFFFF_FFFFFFF1.
  - 0x80000000 × 0x80000000 → 0x40000000_00000000.
  - −1 × −1 → 0x00000000_00000001.
- MULT_SIGNED_EN, signed_i=0 with 0xFFFFFFFF × 2: product is 0x00000001_FFFFFFFE, matching the unsigned build.
